nor2_tt_checker: RTL and testbench
==================================

// Module: nor2_tt_checker
// PURPOSE
// - Self-test wrapper stage around the 2-input NOR cell: drives the cell's
//   A/B inputs through the full truth table and consumes its AorB output.
// - Compares each sampled output against the expected NOR value and counts
//   mismatches; reports pass/fail on a start/done handshake.
// - Sits directly upstream (A/B drivers) and downstream (AorB sampler) of
//   the NOR cell on the project test harness.
// PARAMETERS
// - SETTLE_CYCLES  4  clock cycles waited after each input change before sampling (>=1)
// - LOOPS          1  number of complete truth-table passes per run (>=1)
// - CNT_W          3  width of err_count; the counter saturates at 2^CNT_W-1
// PORTS
// - clk        in   1      single clock; all state changes on the rising edge
// - rst_n      in   1      asynchronous active-low reset
// - start      in   1      request a run; sampled only in IDLE
// - nor_out    in   1      AorB output of the NOR cell under test
// - drive_a    out  1      to cell input A
// - drive_b    out  1      to cell input B
// - busy       out  1      high from the cycle after start is accepted until DONE exits
// - done       out  1      one-cycle pulse at the end of a run
// - pass       out  1      1 if the last run had err_count==0; held until the next start
// - err_count  out  CNT_W  saturating mismatch count for the current/last run
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; drive_a=drive_b=0; busy=done=pass=0;
//   err_count=0; vector index and loop counters=0. Reset mid-run aborts the run
//   immediately with no done pulse.
// - FSM states:
//   - IDLE:   start=1 -> DRIVE; clear err_count and pass; vec=0; loop=0.
//   - DRIVE:  one cycle; {drive_a,drive_b}<=vec -> SETTLE.
//   - SETTLE: count SETTLE_CYCLES cycles -> SAMPLE.
//   - SAMPLE: one cycle. Compare nor_out with ~(drive_a|drive_b); on mismatch,
//     err_count+=1 unless saturated.
//     - vec<3: vec+=1 -> DRIVE.
//     - vec==3 && loop<LOOPS-1: vec=0; loop+=1 -> DRIVE.
//     - otherwise -> DONE.
//   - DONE:   one cycle; done=1; pass=(err_count==0), including the final
//     SAMPLE's result; busy=0 -> IDLE.
// - Vector order {a,b}: 00,01,10,11. Expected nor_out: 1,0,0,0.
// - Per vector: SETTLE_CYCLES+2 cycles. The done pulse is asserted
//   LOOPS*4*(SETTLE_CYCLES+2)+1 cycles after the edge that accepts start.
// - start while busy is ignored and has no side effects. start held high
//   across DONE re-triggers a new run from IDLE.
// - drive_a/drive_b hold the last vector (11) after the run until the next
//   DRIVE or a reset.
// - All outputs are registered; nor_out is sampled only in SAMPLE, so glitches
//   during SETTLE are ignored.
// CONFIGURATION
// - NOR2_FAIL_CAPTURE_EN defined: adds outputs fail_valid (1) and fail_vec (2).
//   - The first mismatching {a,b} in a run is latched and fail_valid is set.
//   - Both are cleared on start acceptance and on reset.
//   - Both hold through DONE until the next start.
// - NOR2_FAIL_CAPTURE_EN undefined: these ports and registers do not exist;
//   all other behaviour is identical.
// TESTING
// - Correct NOR model, defaults, start pulse -> drive sequence 00,01,10,11;
//   done 25 cycles after accept; pass=1; err_count=0.
// - nor_out stuck at 0 -> err_count=1; pass=0; (CAPTURE_EN) fail_vec=00,
//   fail_valid=1.
// - nor_out stuck at 1 -> err_count=3; pass=0; (CAPTURE_EN) fail_vec=01.
// - LOOPS=3, CNT_W=3, stuck at 1 -> 9 mismatches; err_count saturates at 7;
//   done after 73 cycles.
// - start re-asserted every cycle while busy -> exactly one done pulse;
//   err_count not cleared mid-run.
// - rst_n low during SETTLE of vector 10 -> all outputs 0 immediately;
//   no done pulse; next start runs a clean full pass.

Source files
------------

// File: rtl/nor2_tt_checker.sv
// Truth-table self-test stage for a 2-input NOR cell: drives A/B, samples AorB, counts mismatches.
// Optional first-failure capture when NOR2_FAIL_CAPTURE_EN is defined.
module nor2_tt_checker #(
    parameter int SETTLE_CYCLES = 4,
    parameter int LOOPS         = 1,
    parameter int CNT_W         = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             nor_out,
    output logic             drive_a,
    output logic             drive_b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
`ifdef NOR2_FAIL_CAPTURE_EN
    output logic             fail_valid,
    output logic [1:0]       fail_vec,
`endif
    output logic [2:0]       dbg_state
);

    localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;
    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [LOOP_W-1:0] LOOP_LAST   = LOOP_W'(LOOPS - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t            state;
    logic [1:0]        vec;
    logic [LOOP_W-1:0] loop_cnt;
    logic [SET_W-1:0]  settle_cnt;
    logic              mismatch;

    // Compared against the registered drive values, i.e. the vector the cell has settled on.
    assign mismatch  = nor_out ^ ~(drive_a | drive_b);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            vec        <= 2'd0;
            loop_cnt   <= '0;
            settle_cnt <= '0;
            drive_a    <= 1'b0;
            drive_b    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
`ifdef NOR2_FAIL_CAPTURE_EN
            fail_valid <= 1'b0;
            fail_vec   <= 2'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_DRIVE;
                        busy      <= 1'b1;
                        err_count <= '0;
                        pass      <= 1'b0;
                        vec       <= 2'd0;
                        loop_cnt  <= '0;
`ifdef NOR2_FAIL_CAPTURE_EN
                        fail_valid <= 1'b0;
                        fail_vec   <= 2'd0;
`endif
                    end
                end
                S_DRIVE: begin
                    {drive_a, drive_b} <= vec;
                    settle_cnt         <= '0;
                    state              <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= S_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    if (mismatch) begin
                        if (err_count != CNT_MAX) begin
                            err_count <= err_count + 1'b1;
                        end
`ifdef NOR2_FAIL_CAPTURE_EN
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_vec   <= {drive_a, drive_b};
                        end
`endif
                    end
                    if (vec != 2'd3) begin
                        vec   <= vec + 2'd1;
                        state <= S_DRIVE;
                    end else if (loop_cnt != LOOP_LAST) begin
                        vec      <= 2'd0;
                        loop_cnt <= loop_cnt + 1'b1;
                        state    <= S_DRIVE;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // err_count already includes the last SAMPLE's result here.
                    done  <= 1'b1;
                    pass  <= (err_count == '0);
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nor2_tt_checker.sv
// Directed bench for nor2_tt_checker: default instance plus a LOOPS=3 instance for saturation.
// Define NOR2_FAIL_CAPTURE_EN to also check the first-failure capture outputs.
module tb_nor2_tt_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       start3;
    logic [1:0] nor_mode;   // 0: correct NOR, 1: stuck at 0, 2: stuck at 1
    logic       nor_out;
    logic       nor_out3;
    logic       drive_a, drive_b, busy, done, pass;
    logic [2:0] err_count;
    logic [2:0] dbg_state;
    logic       drive_a3, drive_b3, busy3, done3, pass3;
    logic [2:0] err_count3;
    logic [2:0] dbg_state3;
`ifdef NOR2_FAIL_CAPTURE_EN
    logic       fail_valid, fail_valid3;
    logic [1:0] fail_vec, fail_vec3;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign nor_out  = (nor_mode == 2'd0) ? ~(drive_a | drive_b) :
                      (nor_mode == 2'd1) ? 1'b0 : 1'b1;
    assign nor_out3 = 1'b1;

    nor2_tt_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .nor_out(nor_out),
        .drive_a(drive_a), .drive_b(drive_b), .busy(busy), .done(done),
        .pass(pass), .err_count(err_count),
`ifdef NOR2_FAIL_CAPTURE_EN
        .fail_valid(fail_valid), .fail_vec(fail_vec),
`endif
        .dbg_state(dbg_state)
    );

    nor2_tt_checker #(.SETTLE_CYCLES(4), .LOOPS(3), .CNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .nor_out(nor_out3),
        .drive_a(drive_a3), .drive_b(drive_b3), .busy(busy3), .done(done3),
        .pass(pass3), .err_count(err_count3),
`ifdef NOR2_FAIL_CAPTURE_EN
        .fail_valid(fail_valid3), .fail_vec(fail_vec3),
`endif
        .dbg_state(dbg_state3)
    );

    // Pulses start for one accept edge; returns #1 after the accept edge.
    task automatic accept_start(input bit hold);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
    endtask

    // Watches the default instance for budget cycles after the accept edge.
    task automatic wait_done(input int budget, input int drop_k, output int lat,
                             output logic [7:0] seq, output int pulses,
                             output logic [2:0] err_mid);
        lat = -1; seq = '0; pulses = 0; err_mid = '0;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk); #1;
            if (k == drop_k) start = 1'b0;
            if (k == 1 || k == 7 || k == 13 || k == 19) seq = {seq[5:0], drive_a, drive_b};
            if (k == 20) err_mid = err_count;
            if (done) begin
                pulses++;
                if (lat < 0) lat = k;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; start3 = 1'b0; nor_mode = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        total++; if ({drive_a, drive_b} !== 2'b00) $display("FAIL reset_drive got=%b exp=00", {drive_a, drive_b}); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passed++;
        total++; if (pass !== 1'b0) $display("FAIL reset_pass got=%b exp=0", pass); else passed++;
        total++; if (err_count !== 3'd0) $display("FAIL reset_err got=%0d exp=0", err_count); else passed++;
        total++; if (dbg_state !== 3'd0) $display("FAIL reset_state got=%0d exp=0", dbg_state); else passed++;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_correct_nor();
        int lat; int pulses; logic [7:0] seq; logic [2:0] err_mid;
        nor_mode = 2'd0;
        accept_start(1'b0);
        total++; if (busy !== 1'b1) $display("FAIL correct_busy_after_accept got=%b exp=1", busy); else passed++;
        wait_done(30, 0, lat, seq, pulses, err_mid);
        total++; if (seq !== 8'b00_01_10_11) $display("FAIL correct_drive_seq got=%b exp=00011011", seq); else passed++;
        total++; if (lat !== 25) $display("FAIL correct_latency got=%0d exp=25", lat); else passed++;
        total++; if (pulses !== 1) $display("FAIL correct_pulses got=%0d exp=1", pulses); else passed++;
        total++; if (pass !== 1'b1) $display("FAIL correct_pass got=%b exp=1", pass); else passed++;
        total++; if (err_count !== 3'd0) $display("FAIL correct_err got=%0d exp=0", err_count); else passed++;
        total++; if ({drive_a, drive_b} !== 2'b11) $display("FAIL correct_drive_hold got=%b exp=11", {drive_a, drive_b}); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL correct_busy_end got=%b exp=0", busy); else passed++;
    endtask

    task automatic test_stuck0();
        int lat; int pulses; logic [7:0] seq; logic [2:0] err_mid;
        nor_mode = 2'd1;
        accept_start(1'b0);
        wait_done(30, 0, lat, seq, pulses, err_mid);
        total++; if (err_count !== 3'd1) $display("FAIL stuck0_err got=%0d exp=1", err_count); else passed++;
        total++; if (pass !== 1'b0) $display("FAIL stuck0_pass got=%b exp=0", pass); else passed++;
        total++; if (lat !== 25) $display("FAIL stuck0_latency got=%0d exp=25", lat); else passed++;
`ifdef NOR2_FAIL_CAPTURE_EN
        total++; if (fail_valid !== 1'b1) $display("FAIL stuck0_fail_valid got=%b exp=1", fail_valid); else passed++;
        total++; if (fail_vec !== 2'b00) $display("FAIL stuck0_fail_vec got=%b exp=00", fail_vec); else passed++;
`endif
    endtask

    task automatic test_stuck1();
        int lat; int pulses; logic [7:0] seq; logic [2:0] err_mid;
        nor_mode = 2'd2;
        accept_start(1'b0);
        wait_done(30, 0, lat, seq, pulses, err_mid);
        total++; if (err_count !== 3'd3) $display("FAIL stuck1_err got=%0d exp=3", err_count); else passed++;
        total++; if (pass !== 1'b0) $display("FAIL stuck1_pass got=%b exp=0", pass); else passed++;
`ifdef NOR2_FAIL_CAPTURE_EN
        total++; if (fail_valid !== 1'b1) $display("FAIL stuck1_fail_valid got=%b exp=1", fail_valid); else passed++;
        total++; if (fail_vec !== 2'b01) $display("FAIL stuck1_fail_vec got=%b exp=01", fail_vec); else passed++;
`endif
    endtask

    task automatic test_start_while_busy();
        int lat; int pulses; logic [7:0] seq; logic [2:0] err_mid;
        nor_mode = 2'd1;
        accept_start(1'b1);
        wait_done(32, 24, lat, seq, pulses, err_mid);
        total++; if (pulses !== 1) $display("FAIL busy_start_pulses got=%0d exp=1", pulses); else passed++;
        total++; if (lat !== 25) $display("FAIL busy_start_latency got=%0d exp=25", lat); else passed++;
        total++; if (err_mid !== 3'd1) $display("FAIL busy_start_err_mid got=%0d exp=1", err_mid); else passed++;
        total++; if (err_count !== 3'd1) $display("FAIL busy_start_err_end got=%0d exp=1", err_count); else passed++;
    endtask

    task automatic test_retrigger();
        int lat; int pulses; logic [7:0] seq; logic [2:0] err_mid;
        nor_mode = 2'd0;
        accept_start(1'b1);
        wait_done(26, 26, lat, seq, pulses, err_mid);
        total++; if (lat !== 25) $display("FAIL retrig_first_latency got=%0d exp=25", lat); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL retrig_busy got=%b exp=1", busy); else passed++;
        total++; if (pass !== 1'b0) $display("FAIL retrig_pass_cleared got=%b exp=0", pass); else passed++;
        wait_done(30, 0, lat, seq, pulses, err_mid);
        total++; if (lat !== 25) $display("FAIL retrig_second_latency got=%0d exp=25", lat); else passed++;
        total++; if (pass !== 1'b1) $display("FAIL retrig_second_pass got=%b exp=1", pass); else passed++;
    endtask

    task automatic test_reset_mid_run();
        int lat; int pulses; logic [7:0] seq; logic [2:0] err_mid;
        nor_mode = 2'd2;
        accept_start(1'b0);
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
            if (k == 14) begin
                total++; if (err_count !== 3'd1) $display("FAIL midrst_err_before got=%0d exp=1", err_count); else passed++;
                total++; if ({drive_a, drive_b} !== 2'b10) $display("FAIL midrst_vec_before got=%b exp=10", {drive_a, drive_b}); else passed++;
            end
        end
        rst_n = 1'b0;
        #1;
        total++; if ({drive_a, drive_b} !== 2'b00) $display("FAIL midrst_drive got=%b exp=00", {drive_a, drive_b}); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy); else passed++;
        total++; if (err_count !== 3'd0) $display("FAIL midrst_err got=%0d exp=0", err_count); else passed++;
        total++; if (dbg_state !== 3'd0) $display("FAIL midrst_state got=%0d exp=0", dbg_state); else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_done(30, 0, lat, seq, pulses, err_mid);
        total++; if (pulses !== 0) $display("FAIL midrst_no_done got=%0d exp=0", pulses); else passed++;
        nor_mode = 2'd0;
        accept_start(1'b0);
        wait_done(30, 0, lat, seq, pulses, err_mid);
        total++; if (lat !== 25) $display("FAIL midrst_rerun_latency got=%0d exp=25", lat); else passed++;
        total++; if (pass !== 1'b1) $display("FAIL midrst_rerun_pass got=%b exp=1", pass); else passed++;
        total++; if (seq !== 8'b00_01_10_11) $display("FAIL midrst_rerun_seq got=%b exp=00011011", seq); else passed++;
    endtask

    task automatic test_saturation();
        int lat = -1;
        int pulses = 0;
        @(posedge clk); #1;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (done3) begin
                pulses++;
                if (lat < 0) lat = k;
            end
        end
        total++; if (lat !== 73) $display("FAIL sat_latency got=%0d exp=73", lat); else passed++;
        total++; if (pulses !== 1) $display("FAIL sat_pulses got=%0d exp=1", pulses); else passed++;
        total++; if (err_count3 !== 3'd7) $display("FAIL sat_err got=%0d exp=7", err_count3); else passed++;
        total++; if (pass3 !== 1'b0) $display("FAIL sat_pass got=%b exp=0", pass3); else passed++;
    endtask

    initial begin
        test_reset();
        test_correct_nor();
        test_stuck0();
        test_stuck1();
        test_start_while_busy();
        test_retrigger();
        test_reset_mid_run();
        test_saturation();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
